// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-FF input synchronizer, mid-bit sampling FSM,
// registered parallel word with one-cycle done / framing-error strobes.
module uart_rx #(
  parameter int DATA_WIDTH   = 8,
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int BPS          = 9_600
) (
  input  logic                  uart_clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_out,
  output logic                  rx_done,
  output logic                  rx_frame_err
);

  localparam int CPB   = SYS_CLK_FREQ / BPS;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = ($clog2(CPB) > 13) ? $clog2(CPB) : 13;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                  state_q, state_d;
  logic                    meta_q, meta_d;
  logic                    rx_s_q, rx_s_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   rx_out_q, rx_out_d;
  logic                    rx_done_q, rx_done_d;
  logic                    rx_frame_err_q, rx_frame_err_d;
  logic                    rx_s;

  assign rx_s = rx_s_q;

  always_comb begin
    state_d        = state_q;
    meta_d         = rx_in;
    rx_s_d         = meta_q;
    cnt_d          = cnt_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    rx_out_d       = rx_out_q;
    rx_done_d      = 1'b0;
    rx_frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d = '0;
          if (rx_s) begin
            rx_out_d  = shift_q;
            rx_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            rx_frame_err_d = 1'b1;
            state_d        = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      meta_q         <= 1'b1;
      rx_s_q         <= 1'b1;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      rx_out_q       <= '0;
      rx_done_q      <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      meta_q         <= meta_d;
      rx_s_q         <= rx_s_d;
      cnt_q          <= cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      rx_out_q       <= rx_out_d;
      rx_done_q      <= rx_done_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end

  assign rx_out       = rx_out_q;
  assign rx_done      = rx_done_q;
  assign rx_frame_err = rx_frame_err_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that sits directly downstream of `UART_TX`: it consumes the asynchronous serial line (`tx_out` of a transmitter) and recovers 8N1 frames (1 start, DATA_WIDTH data bits LSB-first, 1 stop). Each good frame is presented as a parallel word with a one-cycle `rx_done` strobe. A bad stop bit is flagged with a one-cycle `rx_frame_err` strobe. It runs on the same `uart_clk`/`rst_n` domain and uses the same baud arithmetic as the transmitter.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `SYS_CLK_FREQ`, 50_000_000: `uart_clk` frequency in Hz.
- `BPS`, 9_600: baud rate.
- `uart_clk` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: reset. Asynchronous and active-low.
- `rx_in` input 1: serial line, idle high, asynchronous to `uart_clk`.
- `rx_out` output DATA_WIDTH: last correctly received word; holds until the next good frame.
- `rx_done` output 1: one-cycle pulse when `rx_out` is updated.
- `rx_frame_err` output 1: one-cycle pulse when the stop bit samples low.

## Operation
- Derived constants (integer division):
  - CPB = SYS_CLK_FREQ / BPS (5208 at defaults).
  - HALF = CPB / 2 (2604 at defaults).
- Bit counter is 13+ bits wide, sized to hold CPB-1.
- `rx_in` passes through a 2-FF synchronizer; both flops reset to 1. All decisions below use the synchronized signal `rx_s`.
- States:
  - IDLE: if `rx_s`==0, go to START with cnt=0.
  - START: cnt increments each cycle. When cnt==HALF-1 (mid start bit), sample `rx_s`:
    - 0: go to DATA with cnt=0, bit_idx=0.
    - 1: glitch; go to IDLE with no strobe.
  - DATA: cnt counts 0..CPB-1. When cnt==CPB-1, shift `rx_s` into the shift register at position bit_idx (LSB first), reset cnt, increment bit_idx. After bit DATA_WIDTH-1 go to STOP.
  - STOP: when cnt==CPB-1, sample `rx_s`:
    - 1: load `rx_out` from the shift register, pulse `rx_done`, go to IDLE.
    - 0: pulse `rx_frame_err`, leave `rx_out` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. A break condition must not be decoded as a start bit.
- The return to IDLE happens at mid stop bit, so a start bit that follows the stop bit immediately is caught. Back-to-back frames are supported with zero idle gap.
- `rx_done` and `rx_frame_err` are never high in the same cycle.
- No output handshake: the consumer must take `rx_out` on `rx_done`. A new frame overwrites it.

## Timing
- Reset values:
  - state IDLE; cnt=0; bit_idx=0; shift register 0.
  - `rx_out`=0, `rx_done`=0, `rx_frame_err`=0.
  - Both synchronizer flops = 1.
- Reset asserted mid-frame:
  - Frame is abandoned immediately with no strobe, and all outputs go to their reset values.
  - After release, the receiver waits in IDLE for the next falling edge.
- Latency, taking edge 0 as the first `uart_clk` rising edge that samples `rx_in` low:
  - `rx_s` goes low after edge 1; START is entered at edge 2.
  - Start bit is validated at edge 2+HALF.
  - Data bit i is sampled at edge 2+HALF+(i+1)·CPB.
  - Stop bit is sampled at edge 2+HALF+(DATA_WIDTH+1)·CPB = edge 49478 at defaults. `rx_done` (or `rx_frame_err`) is registered at that edge and is high for exactly one cycle.
- Minimum low pulse accepted as a start bit: low at the synchronizer through edge 2+HALF-2. Shorter lows are rejected as glitches.
- Outputs are registered; there are no combinational paths from `rx_in` to any output.

## Test plan
- Single frame, data 0xA5 driven on `rx_in` at CPB cycles/bit:
  - `rx_out`=0xA5.
  - `rx_done` high for one cycle, registered at edge 49478.
  - `rx_frame_err` stays 0.
- Glitch: `rx_in` low for 1000 cycles, then high:
  - No `rx_done`, no `rx_frame_err`.
  - FSM back in IDLE.
  - A following 0x3C frame is received correctly.
- Framing error: 0x81 with stop bit driven 0, line held low a further 3·CPB:
  - One `rx_frame_err` pulse; `rx_out` keeps its previous value.
  - No new frame decoded until the line returns high.
  - Next frame 0x7E is received correctly.
- Back-to-back 0x00 then 0xFF, zero idle bits between frames:
  - Two `rx_done` pulses, 10·CPB cycles apart.
  - `rx_out` = 0x00, then 0xFF.
- Reset mid-frame: `rst_n` low during data bit 4 for 3 cycles, released while the line is idle high:
  - `rx_out`=0; no strobe for the aborted frame.
  - Next frame 0x5A is received correctly.
- Loopback with `UART_TX` (`tx_out`→`rx_in`), `tx_in`=0x55, one-cycle `tx_en`:
  - `rx_out`=0x55 with one `rx_done` pulse.
  - No `rx_frame_err`.
